// File: rtl/trace_line_arbiter.sv
// Arbitrates two character sources onto one format-checker stream, one '^'...'#' record at a time,
// and reports each record's verdict or its abort (stall or length limit).
module trace_line_arbiter #(
  parameter int STALL_MAX = 16,
  parameter int LEN_MAX   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_char,
  input  logic       req1_valid,
  input  logic [7:0] req1_char,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic [7:0] chk_char,
  output logic       chk_rst,
  input  logic [1:0] chk_format_type,
  output logic       result_valid,
  output logic       result_src,
  output logic [1:0] result_type,
  output logic       result_abort
);

  localparam logic [7:0] C_CARET = 8'h5E;
  localparam logic [7:0] C_HASH  = 8'h23;
  localparam logic [7:0] C_SPACE = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT1,
    S_WAIT2,
    S_ABORT
  } state_t;

  state_t     r_state;
  logic       r_grant;
  logic       r_last_grant;
  logic [5:0] r_len;
  logic [4:0] r_stall;
  logic [7:0] r_chk_char;
  logic       r_chk_rst;
  logic       r_result_valid;
  logic       r_result_src;
  logic [1:0] r_result_type;
  logic       r_result_abort;

  logic       w_caret0;
  logic       w_caret1;
  logic       w_any_caret;
  logic       w_pick;
  logic       w_gnt_valid;
  logic [7:0] w_gnt_char;
  logic [5:0] w_len_inc;
  logic [4:0] w_stall_inc;

  assign w_caret0    = req0_valid && (req0_char == C_CARET);
  assign w_caret1    = req1_valid && (req1_char == C_CARET);
  assign w_any_caret = w_caret0 || w_caret1;
  // On a tie the source not granted last wins; otherwise the lone contender.
  assign w_pick      = (w_caret0 && w_caret1) ? ~r_last_grant : w_caret1;
  assign w_gnt_valid = r_grant ? req1_valid : req0_valid;
  assign w_gnt_char  = r_grant ? req1_char  : req0_char;
  assign w_len_inc   = (r_len == 6'h3F)   ? r_len   : r_len + 6'd1;
  assign w_stall_inc = (r_stall == 5'h1F) ? r_stall : r_stall + 5'd1;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (w_any_caret) begin
            req0_ready = ~w_pick;
            req1_ready = w_pick;
          end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
          end
        end
        S_STREAM: begin
          req0_ready = ~r_grant;
          req1_ready = r_grant;
        end
        default: begin
          req0_ready = 1'b0;
          req1_ready = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_grant        <= 1'b0;
      r_last_grant   <= 1'b1;
      r_len          <= 6'd0;
      r_stall        <= 5'd0;
      r_chk_char     <= C_SPACE;
      r_chk_rst      <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_src   <= 1'b0;
      r_result_type  <= 2'b00;
      r_result_abort <= 1'b0;
    end else begin
      r_chk_char     <= C_SPACE;
      r_chk_rst      <= 1'b0;
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_caret) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_chk_char   <= C_CARET;
            r_len        <= 6'd1;
            r_stall      <= 5'd0;
            r_state      <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_gnt_valid) begin
            r_chk_char <= w_gnt_char;
            r_len      <= w_len_inc;
            r_stall    <= 5'd0;
            if (w_gnt_char == C_HASH)
              r_state <= S_WAIT1;
            else if (int'(r_len) + 1 == LEN_MAX)
              r_state <= S_ABORT;
          end else begin
            r_stall <= w_stall_inc;
            if (int'(r_stall) + 1 == STALL_MAX)
              r_state <= S_ABORT;
          end
        end
        S_WAIT1: r_state <= S_WAIT2;
        S_WAIT2: begin
          // The checker's verdict has settled two cycles after '#'.
          r_result_valid <= 1'b1;
          r_result_src   <= r_grant;
          r_result_type  <= chk_format_type;
          r_result_abort <= 1'b0;
          r_state        <= S_IDLE;
        end
        S_ABORT: begin
          r_chk_rst      <= 1'b1;
          r_result_valid <= 1'b1;
          r_result_src   <= r_grant;
          r_result_type  <= 2'b00;
          r_result_abort <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign chk_char     = r_chk_char;
  assign chk_rst      = r_chk_rst;
  assign result_valid = r_result_valid;
  assign result_src   = r_result_src;
  assign result_type  = r_result_type;
  assign result_abort = r_result_abort;

endmodule

// File: tb/tb_trace_line_arbiter.sv
// Directed bench for trace_line_arbiter: a per-cycle vector table followed by
// hand-written record, stall-abort, length-abort, IDLE-drop and mid-record-reset sequences.
module tb_trace_line_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_char, req1_char;
  logic       req0_ready, req1_ready;
  logic [7:0] chk_char;
  logic       chk_rst;
  logic [1:0] chk_format_type;
  logic       result_valid, result_src, result_abort;
  logic [1:0] result_type;

  int n_checks = 0;
  int n_fail   = 0;

  trace_line_arbiter #(.STALL_MAX(16), .LEN_MAX(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_char(req0_char),
    .req1_valid(req1_valid), .req1_char(req1_char),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .chk_char(chk_char), .chk_rst(chk_rst),
    .chk_format_type(chk_format_type),
    .result_valid(result_valid), .result_src(result_src),
    .result_type(result_type), .result_abort(result_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [7:0] c0;
    logic       v1;
    logic [7:0] c1;
    logic [1:0] fmt;
    logic       r0;
    logic       r1;
    logic [7:0] ch;
    logic       crst;
    logic       rv;
    logic       src;
    logic [1:0] typ;
    logic       ab;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic v0, input logic [7:0] c0, input logic v1,
                              input logic [7:0] c1, input logic [1:0] fmt,
                              input logic r0, input logic r1, input logic [7:0] ch,
                              input logic crst, input logic rv, input logic src,
                              input logic [1:0] typ, input logic ab);
    vec_t v;
    v.v0 = v0; v.c0 = c0; v.v1 = v1; v.c1 = c1; v.fmt = fmt;
    v.r0 = r0; v.r1 = r1; v.ch = ch; v.crst = crst; v.rv = rv;
    v.src = src; v.typ = typ; v.ab = ab;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] c0, input logic v1, input logic [7:0] c1);
    req0_valid = v0; req0_char = c0;
    req1_valid = v1; req1_char = c1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result(input string nm, input logic rv, input logic crst,
                            input logic src, input logic [1:0] typ, input logic ab);
    chk({nm, ".result_valid"}, 8'(result_valid), 8'(rv));
    chk({nm, ".chk_rst"},      8'(chk_rst),      8'(crst));
    if (rv) begin
      chk({nm, ".result_src"},   8'(result_src),   8'(src));
      chk({nm, ".result_type"},  8'(result_type),  8'(typ));
      chk({nm, ".result_abort"}, 8'(result_abort), 8'(ab));
    end
    $display("%s: char=%02h rv=%0b rst=%0b src=%0b type=%02b abort=%0b",
             nm, chk_char, result_valid, chk_rst, result_src, result_type, result_abort);
  endtask

  initial begin
    string s;
    tbl[0]  = mk(1, "a", 1, "x", 2'b00, 1, 1, 8'h20, 0, 0, 0, 2'b00, 0);
    tbl[1]  = mk(1, "b", 1, "y", 2'b00, 1, 1, 8'h20, 0, 0, 0, 2'b00, 0);
    tbl[2]  = mk(1, "^", 1, "^", 2'b00, 1, 0, "^",   0, 0, 0, 2'b00, 0);
    tbl[3]  = mk(1, "A", 1, "^", 2'b00, 1, 0, "A",   0, 0, 0, 2'b00, 0);
    tbl[4]  = mk(0, "B", 1, "^", 2'b00, 1, 0, 8'h20, 0, 0, 0, 2'b00, 0);
    tbl[5]  = mk(1, "#", 1, "^", 2'b00, 1, 0, "#",   0, 0, 0, 2'b00, 0);
    tbl[6]  = mk(1, "q", 1, "^", 2'b00, 0, 0, 8'h20, 0, 0, 0, 2'b00, 0);
    tbl[7]  = mk(1, "q", 1, "^", 2'b10, 0, 0, 8'h20, 0, 1, 0, 2'b10, 0);
    tbl[8]  = mk(1, "^", 1, "^", 2'b00, 0, 1, "^",   0, 0, 0, 2'b10, 0);
    tbl[9]  = mk(1, "z", 1, "^", 2'b00, 0, 1, "^",   0, 0, 0, 2'b10, 0);
    tbl[10] = mk(1, "z", 1, "#", 2'b00, 0, 1, "#",   0, 0, 0, 2'b10, 0);
    tbl[11] = mk(0, "z", 0, "#", 2'b11, 0, 0, 8'h20, 0, 0, 0, 2'b10, 0);
    tbl[12] = mk(0, "z", 0, "#", 2'b11, 0, 0, 8'h20, 0, 1, 1, 2'b11, 0);
    tbl[13] = mk(1, "^", 0, "#", 2'b00, 1, 0, "^",   0, 0, 1, 2'b11, 0);
    tbl[14] = mk(1, "#", 0, "#", 2'b00, 1, 0, "#",   0, 0, 1, 2'b11, 0);
    tbl[15] = mk(0, "#", 0, "#", 2'b01, 0, 0, 8'h20, 0, 0, 1, 2'b11, 0);
    tbl[16] = mk(0, "#", 0, "#", 2'b01, 0, 0, 8'h20, 0, 1, 0, 2'b01, 0);

    reset = 1'b1;
    drive(1, "^", 1, "^");
    chk_format_type = 2'b00;
    step();
    step();
    chk("rst.ready0", 8'(req0_ready), 8'd0);
    chk("rst.ready1", 8'(req1_ready), 8'd0);
    chk("rst.chk_char", chk_char, 8'h20);
    chk("rst.result_src", 8'(result_src), 8'd0);
    chk("rst.result_type", 8'(result_type), 8'd0);
    chk("rst.result_abort", 8'(result_abort), 8'd0);
    chk_result("rst", 0, 0, 0, 2'b00, 0);
    drive(0, 8'h00, 0, 8'h00);
    reset = 1'b0;
    step();

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v0, tbl[i].c0, tbl[i].v1, tbl[i].c1);
      chk_format_type = tbl[i].fmt;
      #1;
      chk($sformatf("vec%0d.ready0", i), 8'(req0_ready), 8'(tbl[i].r0));
      chk($sformatf("vec%0d.ready1", i), 8'(req1_ready), 8'(tbl[i].r1));
      step();
      chk($sformatf("vec%0d.chk_char", i), chk_char, tbl[i].ch);
      chk($sformatf("vec%0d.chk_rst", i), 8'(chk_rst), 8'(tbl[i].crst));
      chk($sformatf("vec%0d.result_valid", i), 8'(result_valid), 8'(tbl[i].rv));
      chk($sformatf("vec%0d.result_src", i), 8'(result_src), 8'(tbl[i].src));
      chk($sformatf("vec%0d.result_type", i), 8'(result_type), 8'(tbl[i].typ));
      chk($sformatf("vec%0d.result_abort", i), 8'(result_abort), 8'(tbl[i].ab));
      $display("vec %0d: char=%02h rv=%0b src=%0b type=%02b abort=%0b",
               i, chk_char, result_valid, result_src, result_type, result_abort);
    end

    // Full record from source 0, checker answers "register".
    s = "^10@00003000: $ 1 <= 0000abcd#";
    for (int i = 0; i < s.len(); i++) begin
      drive(1, s[i], 0, 8'h00);
      #1;
      chk($sformatf("rec.ready0[%0d]", i), 8'(req0_ready), 8'd1);
      step();
      chk($sformatf("rec.chk_char[%0d]", i), chk_char, s[i]);
    end
    drive(0, 8'h00, 0, 8'h00);
    chk_format_type = 2'b01;
    step();
    chk_result("rec.E1", 0, 0, 0, 2'b00, 0);
    step();
    chk_result("rec.E2", 1, 0, 0, 2'b01, 0);

    // Source 1 stalls after "^12@".
    chk_format_type = 2'b11;
    s = "^12@";
    for (int i = 0; i < s.len(); i++) begin
      drive(0, 8'h00, 1, s[i]);
      #1;
      chk($sformatf("stall.ready1[%0d]", i), 8'(req1_ready), 8'd1);
      step();
      chk($sformatf("stall.chk_char[%0d]", i), chk_char, s[i]);
    end
    drive(0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("stall.space[%0d]", i), chk_char, 8'h20);
      chk($sformatf("stall.rv[%0d]", i), 8'(result_valid), 8'd0);
      chk($sformatf("stall.rst[%0d]", i), 8'(chk_rst), 8'd0);
    end
    drive(0, 8'h00, 1, "3");
    #1;
    chk("stall.abort_ready1", 8'(req1_ready), 8'd0);
    step();
    chk_result("stall.abort", 1, 1, 1, 2'b00, 1);
    drive(0, 8'h00, 0, 8'h00);
    step();
    chk_result("stall.after", 0, 0, 0, 2'b00, 0);

    // Source 0 sends 32 characters with no '#'.
    for (int i = 0; i < 32; i++) begin
      logic [7:0] c;
      c = (i == 0) ? 8'h5E : 8'(8'h61 + (i % 26));
      drive(1, c, 0, 8'h00);
      #1;
      chk($sformatf("len.ready0[%0d]", i), 8'(req0_ready), 8'd1);
      step();
      chk($sformatf("len.chk_char[%0d]", i), chk_char, c);
    end
    chk("len.rv_before", 8'(result_valid), 8'd0);
    drive(1, "Q", 0, 8'h00);
    #1;
    chk("len.abort_ready0", 8'(req0_ready), 8'd0);
    step();
    chk_result("len.abort", 1, 1, 0, 2'b00, 1);
    chk("len.abort_char", chk_char, 8'h20);
    drive(0, 8'h00, 0, 8'h00);
    step();
    chk_result("len.after", 0, 0, 0, 2'b00, 0);

    // Non-'^' characters in IDLE are consumed and dropped.
    s = "xyz";
    for (int i = 0; i < s.len(); i++) begin
      drive(0, 8'h00, 1, s[i]);
      #1;
      chk($sformatf("drop.ready1[%0d]", i), 8'(req1_ready), 8'd1);
      step();
      chk($sformatf("drop.chk_char[%0d]", i), chk_char, 8'h20);
      chk($sformatf("drop.rv[%0d]", i), 8'(result_valid), 8'd0);
    end

    // Reset in the middle of a record from source 1.
    drive(0, 8'h00, 1, "^");
    step();
    drive(0, 8'h00, 1, "k");
    step();
    chk("mrst.chk_char_k", chk_char, "k");
    drive(1, "^", 1, "^");
    reset = 1'b1;
    #1;
    chk("mrst.chk_char", chk_char, 8'h20);
    chk("mrst.ready0", 8'(req0_ready), 8'd0);
    chk("mrst.ready1", 8'(req1_ready), 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mrst.rv[%0d]", i), 8'(result_valid), 8'd0);
    end
    reset = 1'b0;
    #1;
    chk("mrst.grant_ready0", 8'(req0_ready), 8'd1);
    chk("mrst.grant_ready1", 8'(req1_ready), 8'd0);
    step();
    chk("mrst.grant_char", chk_char, "^");
    chk_result("mrst.grant", 0, 0, 0, 2'b00, 0);
    drive(0, 8'h00, 0, 8'h00);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
